// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer with registered in_ready.
// Optional downstream stall counter enabled by PIPE_SKID_STALL_CNT_EN.
module pipe_skid_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      stall_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'b00, FULL = 2'b10, SKID = 2'b11} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] skid_d;
  logic in_fire, out_fire, load_in, load_skid, load_from_skid;
  assign out_valid = state[1];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  always_comb begin
    state_nx       = state;
    load_in        = 1'b0;
    load_skid      = 1'b0;
    load_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        load_in  = in_fire;
        state_nx = in_fire ? FULL : EMPTY;
      end
      FULL: begin
        load_in   = in_fire & out_fire;
        load_skid = in_fire & ~out_fire;
        state_nx  = load_skid ? SKID : (out_fire & ~in_fire) ? EMPTY : FULL;
      end
      SKID: begin
        load_from_skid = out_fire;
        state_nx       = out_fire ? FULL : SKID;
      end
      default: state_nx = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nx;
      in_ready <= state_nx != SKID;
    end
  end
  // payload registers may keep stale contents across a flush
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      skid_d   <= '0;
    end else if (!flush) begin
      if (load_in) out_data <= in_data;
      else if (load_from_skid) out_data <= skid_d;
      if (load_skid) skid_d <= in_data;
    end
  end
`ifdef PIPE_SKID_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || flush) stall_cnt <= '0;
    else if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed + random checks of pipe_skid_stage against a two-slot queue model.
module tb_pipe_skid_stage;
  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [15:0] stall_cnt;
  int nv = 0, nerr = 0;
  logic [7:0] q[$];
  logic m_rdy = 1'b1;
  logic m_known = 1'b1;
  int m_cnt = 0;

  pipe_skid_stage #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nv++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt();
`ifdef PIPE_SKID_STALL_CNT_EN
    return 16'(m_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  // one clock: drive inputs, update the queue model at the edge, check 1 time unit later
  task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy,
                       input logic fl, input logic rst);
    logic ifire, ofire;
    reset = rst; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
    @(posedge clk);
    if (rst || fl) begin
      q.delete();
      m_cnt = 0;
      if (rst) m_known = 1'b1;
    end else begin
      ifire = iv && m_rdy;
      ofire = (q.size() != 0) && ordy;
      if (q.size() != 0 && !ordy && m_cnt < 65535) m_cnt++;
      if (ofire) void'(q.pop_front());
      if (ifire) begin
        q.push_back(id);
        m_known = 1'b0;
      end
    end
    m_rdy = q.size() < 2;
    #1;
    chk("out_valid", 16'(out_valid), 16'(q.size() != 0));
    chk("in_ready", 16'(in_ready), 16'(m_rdy));
    if (q.size() != 0) chk("out_data", 16'(out_data), 16'(q[0]));
    else if (m_known) chk("out_data_rst", 16'(out_data), 16'h0000);
    chk("stall_cnt", stall_cnt, exp_cnt());
  endtask

  initial begin
    logic iv;
    logic [7:0] id;
    logic ready_before;
    int k;
    // reset release
    cycle(0, 8'h00, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0);
    chk("rst_data", 16'(out_data), 16'h0000);
    chk("rst_ready", 16'(in_ready), 16'h0001);
    // full-throughput stream
    for (int i = 1; i <= 8; i++) cycle(1, 8'(i), 1, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);
    // backpressure into skid, third value held off
    cycle(1, 8'hA5, 0, 0, 0);
    cycle(1, 8'h5A, 0, 0, 0);
    chk("skid_ready", 16'(in_ready), 16'h0000);
    chk("skid_head", 16'(out_data), 16'h00A5);
    cycle(1, 8'h3C, 0, 0, 0);
    cycle(1, 8'h3C, 0, 0, 0);
    chk("held_head", 16'(out_data), 16'h00A5);
    k = 0;
    do begin
      ready_before = m_rdy;
      cycle(1, 8'h3C, 1, 0, 0);
      k++;
    end while (!ready_before && k < 10);
    chk("accept_3c", 16'(ready_before), 16'h0001);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0, 0);
    // flush from SKID with a dropped input
    cycle(1, 8'hA5, 0, 0, 0);
    cycle(1, 8'h5A, 0, 0, 0);
    cycle(1, 8'hFF, 0, 1, 0);
    chk("flush_valid", 16'(out_valid), 16'h0000);
    chk("flush_ready", 16'(in_ready), 16'h0001);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0, 0);
    // reset with SKID occupied
    cycle(1, 8'h11, 0, 0, 0);
    cycle(1, 8'h22, 0, 0, 0);
    cycle(1, 8'h33, 0, 0, 1);
    chk("rst_mid_valid", 16'(out_valid), 16'h0000);
    cycle(1, 8'h77, 1, 0, 0);
    chk("first_after_rst", 16'(out_data), 16'h0077);
    cycle(0, 8'h00, 1, 0, 0);
    // stall counter: 10 cycles, then run into saturation
    cycle(0, 8'h00, 0, 0, 1);
    cycle(1, 8'h42, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 8'h00, 0, 0, 0);
`ifdef PIPE_SKID_STALL_CNT_EN
    chk("stall_10", stall_cnt, 16'd10);
`else
    chk("stall_10", stall_cnt, 16'd0);
`endif
    for (int i = 0; i < 65530; i++) cycle(0, 8'h00, 0, 0, 0);
`ifdef PIPE_SKID_STALL_CNT_EN
    chk("stall_sat", stall_cnt, 16'hFFFF);
`else
    chk("stall_sat", stall_cnt, 16'd0);
`endif
    cycle(0, 8'h00, 0, 1, 0);
    chk("stall_flush", stall_cnt, 16'd0);
    // random traffic; upstream holds a pending offer until accepted
    iv = 1'b0;
    id = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if (!(iv && !m_rdy)) begin
        iv = 1'($urandom_range(0, 1));
        id = 8'($urandom);
      end
      cycle(iv, id, 1'($urandom_range(0, 2) != 0), $urandom_range(0, 19) == 0,
            $urandom_range(0, 59) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end
endmodule
